// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the MIPS execute stage. It does radix-2 shift-add
// multiply and restoring divide one bit per cycle, and holds the HI/LO registers.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [2:0]       oper,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
        return (~v) + W2'(1);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic             div_r;
    logic             sa_r;
    logic             sb_r;
    logic [WIDTH-1:0] fix_opnd_r;
    logic [WIDTH-1:0] shf_opnd_r;
    logic [WIDTH-1:0] a_raw_r;
    logic [WIDTH-1:0] rem_r;
    logic [W2-1:0]    acc_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             issue_ok_s;
    logic             launch_s;
    logic             mthi_s;
    logic             mtlo_s;
    logic             fix_commit_s;
    logic             signed_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;

    logic [WIDTH-1:0] add_s;
    logic [WIDTH:0]   sum_s;
    logic [W2-1:0]    acc_step_s;
    logic [WIDTH:0]   rem_sh_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_step_s;

    logic [W2-1:0]    prod_s;
    logic             div0_s;
    logic [WIDTH-1:0] quo_fin_s;
    logic [WIDTH-1:0] rem_fin_s;
    logic [WIDTH-1:0] fix_hi_s;
    logic [WIDTH-1:0] fix_lo_s;

    logic             done_nxt_s;
    logic [WIDTH-1:0] hi_nxt_s;
    logic [WIDTH-1:0] lo_nxt_s;

    // FIX also accepts a new request, so a dependent op can issue back to back.
    assign issue_ok_s   = start & ~cancel & ((state_r == ST_IDLE) | (state_r == ST_FIX));
    assign launch_s     = issue_ok_s & (oper <= OP_DIVU);
    assign mthi_s       = issue_ok_s & (oper == OP_MTHI);
    assign mtlo_s       = issue_ok_s & (oper == OP_MTLO);
    assign fix_commit_s = (state_r == ST_FIX) & ~cancel;
    assign signed_s     = ~oper[0];
    assign a_mag_s      = (signed_s & a[WIDTH-1]) ? neg_w(a) : a;
    assign b_mag_s      = (signed_s & b[WIDTH-1]) ? neg_w(b) : b;

    // Multiply step: add the multiplicand into the top half, then shift the whole accumulator right.
    assign add_s      = shf_opnd_r[0] ? fix_opnd_r : {WIDTH{1'b0}};
    assign sum_s      = {1'b0, acc_r[W2-1:WIDTH]} + {1'b0, add_s};
    assign acc_step_s = {sum_s, acc_r[WIDTH-1:1]};

    // Divide step: the dividend MSB is shifted into the remainder, and the quotient bit enters at the LSB.
    assign rem_sh_s   = {rem_r, shf_opnd_r[WIDTH-1]};
    assign ge_s       = (rem_sh_s >= {1'b0, fix_opnd_r});
    assign rem_step_s = ge_s ? (rem_sh_s[WIDTH-1:0] - fix_opnd_r) : rem_sh_s[WIDTH-1:0];

    assign prod_s    = (sa_r ^ sb_r) ? neg_2w(acc_r) : acc_r;
    assign div0_s    = (fix_opnd_r == {WIDTH{1'b0}});
    assign quo_fin_s = div0_s ? {WIDTH{1'b1}} : ((sa_r ^ sb_r) ? neg_w(shf_opnd_r) : shf_opnd_r);
    assign rem_fin_s = div0_s ? a_raw_r : (sa_r ? neg_w(rem_r) : rem_r);
    assign fix_hi_s  = div_r ? rem_fin_s : prod_s[W2-1:WIDTH];
    assign fix_lo_s  = div_r ? quo_fin_s : prod_s[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX: begin
                if (launch_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic; an MTHI/MTLO taken in FIX is younger and wins over the result.
    always_comb begin
        done_nxt_s = fix_commit_s | mthi_s | mtlo_s;
        if (mthi_s) begin
            hi_nxt_s = a;
        end else if (fix_commit_s) begin
            hi_nxt_s = fix_hi_s;
        end else begin
            hi_nxt_s = hi_r;
        end
        if (mtlo_s) begin
            lo_nxt_s = a;
        end else if (fix_commit_s) begin
            lo_nxt_s = fix_lo_s;
        end else begin
            lo_nxt_s = lo_r;
        end
    end

    // Operand latch and per-cycle iteration datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= {CW{1'b0}};
            div_r      <= 1'b0;
            sa_r       <= 1'b0;
            sb_r       <= 1'b0;
            fix_opnd_r <= {WIDTH{1'b0}};
            shf_opnd_r <= {WIDTH{1'b0}};
            a_raw_r    <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            acc_r      <= {W2{1'b0}};
        end else if (launch_s) begin
            cnt_r      <= CW'(WIDTH - 1);
            div_r      <= oper[1];
            sa_r       <= signed_s & a[WIDTH-1];
            sb_r       <= signed_s & b[WIDTH-1];
            fix_opnd_r <= oper[1] ? b_mag_s : a_mag_s;
            shf_opnd_r <= oper[1] ? a_mag_s : b_mag_s;
            a_raw_r    <= a;
            rem_r      <= {WIDTH{1'b0}};
            acc_r      <= {W2{1'b0}};
        end else if (state_r == ST_RUN) begin
            if (cnt_r != {CW{1'b0}}) begin
                cnt_r <= cnt_r - CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (div_r) begin
                rem_r      <= rem_step_s;
                shf_opnd_r <= {shf_opnd_r[WIDTH-2:0], ge_s};
            end else begin
                acc_r      <= acc_step_s;
                shf_opnd_r <= {1'b0, shf_opnd_r[WIDTH-1:1]};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= done_nxt_s;
            hi_r   <= hi_nxt_s;
            lo_r   <= lo_nxt_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed, table-driven bench for mdu_iter at WIDTH=32. It also has hand-written
// sequences for back-to-back issue, cancel, ignored start, async reset and no-ops.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         rst    = 1'b0;
    logic         start  = 1'b0;
    logic         cancel = 1'b0;
    logic [2:0]   oper   = 3'd0;
    logic [W-1:0] a      = 32'd0;
    logic [W-1:0] b      = 32'd0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel), .oper(oper),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present a request for one cycle; returns just after the accepting edge.
    task automatic launch(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        oper  = op;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done; lat stays -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            busy_cnt += int'(busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int bcnt;
        logic done_seen;
        logic busy_seen;

        vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{3'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        vecs[7]  = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{3'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[10] = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[11] = '{3'd0, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};

        #1 rst = 1'b1;
        #3;
        check("rst_busy", W'(busy), 32'd0);
        check("rst_done", W'(done), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].op, vecs[i].va, vecs[i].vb);
            wait_done(lat, bcnt);
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            check($sformatf("v%0d_latency", i), W'(lat), 32'd33);
            check($sformatf("v%0d_busy_cycles", i), W'(bcnt), 32'd33);
            @(negedge clk);
            check($sformatf("v%0d_done_drop", i), W'(done), 32'd0);
        end

        // Back-to-back: the second start is presented so that it is sampled at the FIX edge.
        launch(3'd1, 32'd3, 32'd5);
        for (int c = 0; c <= 32; c++) begin
            @(negedge clk);
        end
        start = 1'b1;
        oper  = 3'd0;
        a     = 32'hFFFFFFFE;
        b     = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_first_done", W'(done), 32'd1);
        check("b2b_busy_kept", W'(busy), 32'd1);
        check("b2b_first_lo", lo, 32'd15);
        check("b2b_first_hi", hi, 32'd0);
        wait_done(lat, bcnt);
        check("b2b_second_latency", W'(lat), 32'd32);
        check("b2b_second_hi", hi, 32'hFFFFFFFF);
        check("b2b_second_lo", lo, 32'hFFFFFFEE);

        // MTHI / MTLO preload
        launch(3'd4, 32'h00001234, 32'd0);
        @(negedge clk);
        check("mthi_done", W'(done), 32'd1);
        check("mthi_busy", W'(busy), 32'd0);
        check("mthi_hi", hi, 32'h00001234);
        launch(3'd5, 32'h00005678, 32'd0);
        @(negedge clk);
        check("mtlo_done", W'(done), 32'd1);
        check("mtlo_busy", W'(busy), 32'd0);
        check("mtlo_lo", lo, 32'h00005678);
        check("mtlo_hi_kept", hi, 32'h00001234);

        // A start while busy is ignored, and a cancel in RUN aborts the operation.
        launch(3'd0, 32'd3, 32'd5);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 4) begin
                start = 1'b1;
                oper  = 3'd2;
                a     = 32'd100;
                b     = 32'd7;
            end else if (c == 5) begin
                start = 1'b0;
            end else if (c == 9) begin
                cancel = 1'b1;
            end
        end
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", W'(busy), 32'd0);
        check("cancel_done", W'(done), 32'd0);
        check("cancel_hi", hi, 32'h00001234);
        check("cancel_lo", lo, 32'h00005678);
        done_seen = 1'b0;
        busy_seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            done_seen |= done;
            busy_seen |= busy;
        end
        check("cancel_no_late_done", W'(done_seen), 32'd0);
        check("cancel_no_late_busy", W'(busy_seen), 32'd0);
        check("cancel_hi_hold", hi, 32'h00001234);

        // Asynchronous reset in the middle of RUN
        launch(3'd1, 32'h0000FFFF, 32'h0000FFFF);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
        end
        check("pre_rst_busy", W'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", W'(busy), 32'd0);
        check("async_rst_done", W'(done), 32'd0);
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        launch(3'd1, 32'd6, 32'd7);
        wait_done(lat, bcnt);
        check("post_rst_lo", lo, 32'd42);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_latency", W'(lat), 32'd33);

        // An oper of 6 is a no-op, and cancel in IDLE overrides start.
        launch(3'd6, 32'h0000AAAA, 32'd0);
        @(negedge clk);
        check("noop_done", W'(done), 32'd0);
        check("noop_busy", W'(busy), 32'd0);
        check("noop_hi", hi, 32'd0);
        start  = 1'b1;
        cancel = 1'b1;
        oper   = 3'd5;
        a      = 32'h0000DEAD;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        check("idle_cancel_done", W'(done), 32'd0);
        check("idle_cancel_lo", lo, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
